multicycle_control: RTL and testbench

Multi-cycle sequencer for the 8-bit datapath: register file, ALU, data memory and PC counter. It replaces single-cycle decode with a state machine that fetches one instruction over a handshake, then drives the datapath select/enable signals state by state. It tolerates variable-latency instruction and data memories. It also owns the sticky status flags (infinite loop, overflow) and a retired-instruction counter.

---
 rtl/multicycle_control_pkg.sv | 39 +++
 rtl/multicycle_control_decode.sv | 33 +++
 rtl/multicycle_control.sv | 111 +++++++++++
 tb/tb_multicycle_control.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multi-cycle sequencer and its control decoder.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;
  localparam int RS_MSB  = 5;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 2;
  localparam int IMM_MSB = 1;
  localparam int IMM_LSB = 0;

  // jmp to itself: the only way a program can stop
  localparam logic [1:0] IMM_SELF = 2'b11;

  function automatic logic [1:0] opcode_of(input logic [7:0] ir);
    return ir[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [1:0] imm_of(input logic [7:0] ir);
    return ir[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational map from {state, opcode, imm} to the datapath select/enable lines.
module control_decode
  import multicycle_control_pkg::*;
(
  input  state_e     state_i,
  input  logic [1:0] op_i,
  input  logic [1:0] imm_i,
  output logic       branch_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       mem_to_reg_o,
  output logic       alu_op_o,
  output logic       alu_src_o,
  output logic       reg_write_o,
  output logic       reg_dst_o
);

  logic in_dp, is_ls;

  always_comb begin
    in_dp        = (state_i == S_EXEC) || (state_i == S_MEM) || (state_i == S_WB);
    is_ls        = (op_i == OP_LW) || (op_i == OP_SW);
    alu_op_o     = in_dp && (op_i != OP_JMP);
    alu_src_o    = in_dp && is_ls;
    branch_o     = (state_i == S_EXEC) && (op_i == OP_JMP) && (imm_i != IMM_SELF);
    mem_read_o   = (state_i == S_MEM) && (op_i == OP_LW);
    mem_write_o  = (state_i == S_MEM) && (op_i == OP_SW);
    reg_write_o  = (state_i == S_WB);
    reg_dst_o    = (state_i == S_WB) && (op_i == OP_ADD);
    mem_to_reg_o = (state_i == S_WB) && (op_i == OP_LW);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: instruction fetch handshake, per-state datapath control,
// sticky loop/overflow flags and a retired-instruction counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int RETIRE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          instruction,
  input  logic                instrValid,
  input  logic                memReady,
  input  logic                aluOverflow,
  output logic                instrReq,
  output logic [7:0]          irOut,
  output logic                sigPcInc,
  output logic                sigBranch,
  output logic                sigMemRead,
  output logic                sigMemWrite,
  output logic                sigMemtoReg,
  output logic                sigALUOp,
  output logic                sigALUSrc,
  output logic                sigRegWrite,
  output logic                sigRegDst,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired,
  output logic [1:0]          flags
);

  state_e              state_q;
  logic [7:0]          ir_q;
  logic [RETIRE_W-1:0] retired_q;
  logic [1:0]          flags_q;
  logic [1:0]          op;

  assign op = opcode_of(ir_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= 8'h00;
      retired_q <= '0;
      flags_q   <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE:   state_q <= S_FETCH;
        S_FETCH: if (instrValid) begin
          ir_q    <= instruction;
          state_q <= S_DECODE;
        end
        S_DECODE: state_q <= S_EXEC;
        S_EXEC: begin
          case (op)
            OP_ADD: begin
              if (aluOverflow) flags_q[1] <= 1'b1;
              state_q <= S_WB;
            end
            OP_LW, OP_SW: state_q <= S_MEM;
            default: begin
              // a jmp retires in EXEC, including the self-loop that halts
              retired_q <= retired_q + 1'b1;
              if (imm_of(ir_q) == IMM_SELF) begin
                flags_q[0] <= 1'b1;
                state_q    <= S_HALT;
              end else begin
                state_q <= S_FETCH;
              end
            end
          endcase
        end
        S_MEM: if (memReady) begin
          if (op == OP_LW) begin
            state_q <= S_WB;
          end else begin
            retired_q <= retired_q + 1'b1;
            state_q   <= S_FETCH;
          end
        end
        S_WB: begin
          retired_q <= retired_q + 1'b1;
          state_q   <= S_FETCH;
        end
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  control_decode u_decode (
    .state_i      (state_q),
    .op_i         (op),
    .imm_i        (imm_of(ir_q)),
    .branch_o     (sigBranch),
    .mem_read_o   (sigMemRead),
    .mem_write_o  (sigMemWrite),
    .mem_to_reg_o (sigMemtoReg),
    .alu_op_o     (sigALUOp),
    .alu_src_o    (sigALUSrc),
    .reg_write_o  (sigRegWrite),
    .reg_dst_o    (sigRegDst)
  );

  // PC steps on the same edge that captures IR, so the pulse is qualified by the handshake
  assign sigPcInc = (state_q == S_FETCH) && instrValid;
  assign instrReq = (state_q == S_FETCH);
  assign irOut    = ir_q;
  assign state    = state_q;
  assign retired  = retired_q;
  assign flags    = flags_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench: each instruction is expanded into its expected per-cycle output schedule,
// and a negedge process compares every DUT output against that schedule.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instruction = 8'h00;
  logic       instrValid = 1'b0, memReady = 1'b0, aluOverflow = 1'b0;
  logic       instrReq, sigPcInc, sigBranch, sigMemRead, sigMemWrite, sigMemtoReg;
  logic       sigALUOp, sigALUSrc, sigRegWrite, sigRegDst;
  logic [7:0] irOut, retired;
  logic [2:0] state;
  logic [1:0] flags;

  always #5 clk = ~clk;

  multicycle_control #(.RETIRE_W(8)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .instrValid(instrValid),
    .memReady(memReady), .aluOverflow(aluOverflow), .instrReq(instrReq), .irOut(irOut),
    .sigPcInc(sigPcInc), .sigBranch(sigBranch), .sigMemRead(sigMemRead),
    .sigMemWrite(sigMemWrite), .sigMemtoReg(sigMemtoReg), .sigALUOp(sigALUOp),
    .sigALUSrc(sigALUSrc), .sigRegWrite(sigRegWrite), .sigRegDst(sigRegDst),
    .state(state), .retired(retired), .flags(flags)
  );

  // {state, req, pcinc, br, mrd, mwr, m2r, aluop, alusrc, rw, rdst, ir, retired, flags}
  logic [30:0] act, exp;
  assign act = {state, instrReq, sigPcInc, sigBranch, sigMemRead, sigMemWrite, sigMemtoReg,
                sigALUOp, sigALUSrc, sigRegWrite, sigRegDst, irOut, retired, flags};

  int    n_chk = 0, n_err = 0;
  bit    chk_en = 0, adv = 0;
  string tag = "";
  logic [7:0] m_ir, m_ret;
  logic [1:0] m_fl;

  always @(negedge clk) if (chk_en) begin
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic next_cyc();
    if (!adv) begin
      @(posedge clk); #1;
    end
    adv = 0;
  endtask

  task automatic settle();
    chk_en = 0;
    @(posedge clk); #1;
    adv = 1;
  endtask

  // ctl = {req, pcinc, br, mrd, mwr, m2r, aluop, alusrc, rw, rdst}
  task automatic expect_cyc(input logic [2:0] st, input logic [9:0] ctl);
    exp = {st, ctl, m_ir, m_ret, m_fl};
    chk_en = 1;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    chk_en = 0;
    adv = 0;
    @(posedge clk); #1;
    reset = 1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_ir", irOut, 0);
    chk("rst_retired", retired, 0);
    chk("rst_flags", flags, 0);
    chk("rst_ctl", {instrReq, sigPcInc, sigBranch, sigMemRead, sigMemWrite, sigMemtoReg,
                    sigALUOp, sigALUSrc, sigRegWrite, sigRegDst}, 0);
    @(posedge clk); #1;
    reset = 0;
    m_ir = 0; m_ret = 0; m_fl = 0;
    instrValid = 1; memReady = 1; aluOverflow = 1;
    tag = "idle";
    expect_cyc(3'd0, 10'b0);
  endtask

  // fw = cycles instrValid stays low, mw = cycles memReady stays low,
  // abort = assert reset during the first MEM cycle
  task automatic do_instr(input logic [7:0] ins, input int fw, input int mw,
                          input bit ovf, input bit abort);
    logic [1:0] op, imm;
    bit ls;
    op = ins[7:6]; imm = ins[1:0];
    ls = (op == 2'd1) || (op == 2'd2);
    tag = $sformatf("ins%h_fetch", ins);
    for (int i = 0; i < fw; i++) begin
      next_cyc();
      instruction = ~ins; instrValid = 0; memReady = 1; aluOverflow = 1;
      expect_cyc(3'd1, 10'b1000000000);
    end
    next_cyc();
    instruction = ins; instrValid = 1; memReady = 0; aluOverflow = 0;
    expect_cyc(3'd1, 10'b1100000000);
    m_ir = ins;
    next_cyc();
    tag = $sformatf("ins%h_decode", ins);
    instruction = 8'hFF; instrValid = 1; memReady = 1; aluOverflow = 1;
    expect_cyc(3'd2, 10'b0);
    next_cyc();
    tag = $sformatf("ins%h_exec", ins);
    aluOverflow = ovf;
    expect_cyc(3'd3, {3'b000, (op == 2'd3) && (imm != 2'd3), 3'b000, op != 2'd3, ls, 2'b00});
    if (op == 2'd0 && ovf) m_fl[1] = 1;
    if (op == 2'd3) begin
      m_ret++;
      if (imm == 2'd3) m_fl[0] = 1;
      return;
    end
    if (ls) begin
      tag = $sformatf("ins%h_mem", ins);
      for (int i = 0; i <= mw; i++) begin
        next_cyc();
        memReady = (i == mw); aluOverflow = 1; instrValid = 1;
        expect_cyc(3'd4, {3'b000, op == 2'd1, op == 2'd2, 1'b0, 2'b11, 2'b00});
        if (abort) begin
          chk_en = 0;
          reset = 1;
          #1;
          chk("abort_memwrite", sigMemWrite, 0);
          chk("abort_state", state, 0);
          chk("abort_retired", retired, 0);
          chk("abort_flags", flags, 0);
          return;
        end
      end
      if (op == 2'd2) begin
        m_ret++;
        return;
      end
    end
    next_cyc();
    tag = $sformatf("ins%h_wb", ins);
    aluOverflow = 1; memReady = 1;
    expect_cyc(3'd5, {5'b00000, op == 2'd1, 1'b1, ls, 1'b1, op == 2'd0});
    m_ret++;
  endtask

  task automatic halt_cycles(input int n);
    tag = "halt";
    for (int i = 0; i < n; i++) begin
      next_cyc();
      instruction = 8'($urandom); instrValid = 1; memReady = 1; aluOverflow = 1;
      expect_cyc(3'd6, 10'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    do_instr(8'h1B, 0, 0, 0, 0);          // add, minimum latency
    settle(); chk("add_retired", retired, 1);
    do_instr(8'h5D, 0, 3, 0, 0);          // lw with three memReady wait cycles
    settle(); chk("lw_retired", retired, 2);
    do_instr(8'h9E, 2, 0, 0, 0);          // sw after two fetch waits
    do_instr(8'hC2, 1, 0, 0, 0);          // jmp, branch taken
    settle(); chk("jmp_retired", retired, 4);
    do_instr(8'h1B, 0, 0, 1, 0);          // add overflowing
    do_instr(8'h27, 0, 0, 0, 0);
    do_instr(8'h06, 1, 0, 0, 0);
    do_instr(8'h3F, 0, 0, 0, 0);
    settle();
    chk("ovf_sticky", flags, 2'b10);
    chk("ovf_retired", retired, 8);
    do_instr(8'h9E, 0, 5, 0, 1);          // sw abandoned by reset mid-MEM
    do_reset();
    do_instr(8'hC3, 0, 0, 0, 0);          // self-loop
    settle();
    chk("halt_flags", flags, 2'b01);
    chk("halt_state", state, 6);
    chk("halt_retired", retired, 1);
    halt_cycles(20);
    do_reset();
    for (int k = 0; k < 256; k++) do_instr(8'hC0, 0, 0, 0, 0);
    settle();
    chk("wrap_retired", retired, 0);
    chk("wrap_flags", flags, 0);
    chk("wrap_state", state, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
